// File: rtl/vend_display_ctrl_pkg.sv
// vend_disp_pkg: shared constants and helpers for the vending display controller.
//   - display mode codes (MODE_IDLE..MODE_REFUND)
//   - 4-bit glyph codes understood by the downstream 7-segment driver
//   - item_price(): price table lookup, returns count units plus a known flag
//   - SAT_CENTS: largest amount that fits on three BCD digits
//   - state_t: controller FSM state encoding (also exported for debug)
package vend_disp_pkg;

    localparam logic [2:0] MODE_IDLE   = 3'd1;
    localparam logic [2:0] MODE_PRICE  = 3'd2;
    localparam logic [2:0] MODE_OOS    = 3'd3;
    localparam logic [2:0] MODE_INSERT = 3'd4;
    localparam logic [2:0] MODE_REFUND = 3'd5;

    localparam logic [3:0] GLYPH_BLANK = 4'hF;
    localparam logic [3:0] GLYPH_DASH  = 4'h6;
    localparam logic [3:0] GLYPH_E     = 4'hE;
    localparam logic [3:0] GLYPH_C     = 4'hC;
    localparam logic [3:0] GLYPH_9     = 4'h9;
    localparam logic [3:0] GLYPH_4     = 4'h4;
    localparam logic [3:0] GLYPH_0     = 4'h0;

    localparam logic [9:0] SAT_CENTS  = 10'd999;
    localparam int         BCD_SHIFTS = 10;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_CONV  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic       known;
        logic [3:0] counts;
    } price_t;

    function automatic price_t item_price(input logic [7:0] code);
        price_t p;
        p.known  = 1'b1;
        p.counts = 4'd0;
        case (code)
            8'hA2:   p.counts = 4'd5;
            8'hB3:   p.counts = 4'd4;
            8'hD5:   p.counts = 4'd9;
            8'hE8:   p.counts = 4'd3;
            default: p.known  = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_display_ctrl_if.sv
// vend_display_ctrl_if: display-update request channel from the vending FSM.
//   upd_valid / upd_ready : handshake. A request transfers on a rising clock edge
//                           where both are high; the payload (mode, itemcode,
//                           inserted, refund) must be stable while upd_valid is
//                           high and is don't-care afterwards. upd_valid may be
//                           held high to queue the next request.
//   mode      : display mode code (see vend_disp_pkg)
//   itemcode  : selected item, used in price mode
//   inserted  : inserted money count, used in insert mode
//   refund    : refund count, used in refund mode
// Modports: master = request source, slave = display controller.
interface vend_display_ctrl_if #(
    parameter int MONEY_W = 4
);
    logic               upd_valid;
    logic               upd_ready;
    logic [2:0]         mode;
    logic [7:0]         itemcode;
    logic [MONEY_W-1:0] inserted;
    logic [MONEY_W-1:0] refund;

    modport master (
        output upd_valid, mode, itemcode, inserted, refund,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, mode, itemcode, inserted, refund,
        output upd_ready
    );
endinterface

// File: rtl/vend_display_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential 10-bit binary to 3-digit BCD converter (double dabble),
// one shift per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load i_bin and begin a conversion (restarts any running one)
//   i_bin      : binary value, must be <= 999
//   o_last     : high in the cycle whose closing edge performs the final shift;
//                o_bcd is valid from the following cycle until the next start
//   o_bcd      : {hundreds, tens, ones}
module bin2bcd_seq
    import vend_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [9:0]  i_bin,
    output logic        o_last,
    output logic [11:0] o_bcd
);

    logic [9:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [11:0] w_adj;

    // Add-3 correction on every BCD digit that would overflow when doubled.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 3; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= 4'(BCD_SHIFTS);
        end else if (r_cnt != 4'd0) begin
            r_bcd <= {w_adj[10:0], r_bin[9]};
            r_bin <= {r_bin[8:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = (r_cnt == 4'd1);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/vend_display_ctrl.sv
// vend_display_ctrl: sequential vending-machine display controller.
// Accepts display updates, converts the money amount to 3-digit BCD cents and
// commits all digits atomically 11 clocks after the accepting edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   upd_if      : update request channel (slave side)
//   digits_o    : glyph codes, digit k at [4k+3:4k]; slots above 5 always blank
//   disp_valid  : one-cycle pulse in the cycle after a commit
//   ovf         : last committed amount was saturated to 999 cents
//   dbg_state   : current FSM state
// Optional feature macro VEND_DISPLAY_BLINK_EN: out-of-stock and refund screens
// alternate between content and blank every BLINK_DIV clocks, content first.
module vend_display_ctrl
    import vend_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MONEY_W    = 4,
    parameter int UNIT_CENTS = 25,
    parameter int BLINK_DIV  = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vend_display_ctrl_if.slave      upd_if,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    disp_valid,
    output logic                    ovf,
    output state_t                  dbg_state
);

    localparam int CENTS_W = MONEY_W + 5;
    localparam int AMT_W   = (MONEY_W > 4) ? MONEY_W : 4;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_commit;
    logic                    w_conv_last;
    logic [11:0]             w_bcd;
    price_t                  w_price;
    logic [AMT_W-1:0]        w_amount;
    logic [CENTS_W-1:0]      w_cents;
    logic                    w_sat;
    logic [9:0]              w_bin;
    logic [23:0]             w_layout;
    logic [4*NUM_DIGITS-1:0] w_digits_nxt;

    logic [2:0]              r_mode;
    logic [7:0]              r_item;
    logic                    r_known;
    logic                    r_ovf_pend;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_ovf;
    logic                    r_disp_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_READY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_READY: if (upd_if.upd_valid) w_state_nxt = S_CONV;
            S_CONV:  if (w_conv_last)      w_state_nxt = S_DONE;
            S_DONE:                        w_state_nxt = S_READY;
            default:                       w_state_nxt = S_READY;
        endcase
    end

    always_comb begin
        w_ready  = (r_state == S_READY);
        w_accept = w_ready && upd_if.upd_valid;
        w_commit = (r_state == S_DONE);
    end

    assign upd_if.upd_ready = w_ready;
    assign dbg_state        = r_state;

    // ---------------- amount selection and scaling ----------------
    // Computed straight from the request so the converter is loaded on the
    // accepting edge; unknown price items carry 0 counts.
    assign w_price = item_price(upd_if.itemcode);

    always_comb begin
        case (upd_if.mode)
            MODE_PRICE:  w_amount = AMT_W'(w_price.counts);
            MODE_INSERT: w_amount = AMT_W'(upd_if.inserted);
            MODE_REFUND: w_amount = AMT_W'(upd_if.refund);
            default:     w_amount = '0;
        endcase
    end

    assign w_cents = CENTS_W'(w_amount) * CENTS_W'(UNIT_CENTS);
    assign w_sat   = 32'(w_cents) > 32'(SAT_CENTS);
    assign w_bin   = w_sat ? SAT_CENTS : 10'(w_cents);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= '0;
            r_item     <= '0;
            r_known    <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else if (w_accept) begin
            r_mode     <= upd_if.mode;
            r_item     <= upd_if.itemcode;
            r_known    <= w_price.known;
            r_ovf_pend <= w_sat;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_bin   (w_bin),
        .o_last  (w_conv_last),
        .o_bcd   (w_bcd)
    );

    // ---------------- digit layout (digit5..digit0) ----------------
    always_comb begin
        w_layout = {6{GLYPH_BLANK}};
        case (r_mode)
            MODE_IDLE:   w_layout = {GLYPH_BLANK, GLYPH_9, GLYPH_E, GLYPH_4, GLYPH_4, GLYPH_0};
            MODE_PRICE:  if (r_known) w_layout = {r_item, GLYPH_BLANK, w_bcd};
            MODE_OOS:    w_layout = {6{GLYPH_DASH}};
            MODE_INSERT: w_layout = {GLYPH_E, GLYPH_BLANK, GLYPH_BLANK, w_bcd};
            MODE_REFUND: w_layout = {GLYPH_C, GLYPH_BLANK, GLYPH_BLANK, w_bcd};
            default:     w_layout = {6{GLYPH_BLANK}};
        endcase
        w_digits_nxt        = '1;
        w_digits_nxt[23:0]  = w_layout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits     <= '1;
            r_ovf        <= 1'b0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= w_commit;
            if (w_commit) begin
                r_digits <= w_digits_nxt;
                r_ovf    <= r_ovf_pend;
            end
        end
    end

    assign disp_valid = r_disp_valid;
    assign ovf        = r_ovf;

    // ---------------- optional blink ----------------
`ifdef VEND_DISPLAY_BLINK_EN
    logic [31:0] r_blink_cnt;
    logic        r_blink_phase;
    logic        r_blink_on;

    // Restart on every commit so fresh content is always shown first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_on    <= 1'b0;
        end else if (w_commit) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_on    <= (r_mode == MODE_OOS) || (r_mode == MODE_REFUND);
        end else if (r_blink_cnt == 32'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 32'd1;
        end
    end

    assign digits_o = (r_blink_on && r_blink_phase) ? '1 : r_digits;
`else
    wire w_blink_unused = (BLINK_DIV > 0);
    assign digits_o = r_digits;
`endif

endmodule

// File: tb/tb_vend_display_ctrl.sv
module tb_vend_display_ctrl;
    import vend_disp_pkg::*;

    localparam int ND = 7;
    localparam int MW = 6;
    localparam int UC = 25;
    localparam int BD = 4;
    localparam int DW = 4 * ND;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vend_display_ctrl_if #(.MONEY_W(MW)) upd_if ();
    logic [DW-1:0] digits_o;
    logic          disp_valid;
    logic          ovf;
    state_t        dbg_state;

    vend_display_ctrl #(
        .NUM_DIGITS (ND),
        .MONEY_W    (MW),
        .UNIT_CENTS (UC),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_if     (upd_if),
        .digits_o   (digits_o),
        .disp_valid (disp_valid),
        .ovf        (ovf),
        .dbg_state  (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    int dv_pulses   = 0;
    int exp_pulses  = 0;
    always @(negedge clk) if (disp_valid === 1'b1) dv_pulses++;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    bit            exp_ovf_q[$];
    bit            exp_blink_q[$];

    logic [DW-1:0] shown_content = '1;
    bit            shown_blinks  = 1'b0;
    bit            shown_ovf     = 1'b0;
    int            commit_cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // What the display should show right now, given the last commit.
    function automatic logic [DW-1:0] disp_now();
`ifdef VEND_DISPLAY_BLINK_EN
        if (shown_blinks && (((cyc - commit_cyc) / BD) % 2 == 1)) return '1;
`endif
        return shown_content;
    endfunction

    // Reference model: display content straight from the mode rules.
    task automatic model(input int m, input logic [7:0] it, input int ins, input int rf,
                         output logic [DW-1:0] d, output bit ov, output bit bl);
        int amt;
        int cents;
        int price;
        bit known;
        logic [3:0] g [5:0];
        price = 0;
        known = 1'b1;
        case (it)
            8'hA2:   price = 5;
            8'hB3:   price = 4;
            8'hD5:   price = 9;
            8'hE8:   price = 3;
            default: known = 1'b0;
        endcase
        amt = 0;
        if (m == 2) amt = price;
        if (m == 4) amt = ins;
        if (m == 5) amt = rf;
        cents = amt * UC;
        ov = 1'b0;
        if (cents > 999) begin
            cents = 999;
            ov = 1'b1;
        end
        g = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        case (m)
            1: g = '{4'hF, 4'h9, 4'hE, 4'h4, 4'h4, 4'h0};
            2: if (known) g = '{it[7:4], it[3:0], 4'hF, 4'(cents / 100), 4'((cents / 10) % 10), 4'(cents % 10)};
            3: g = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6};
            4: g = '{4'hE, 4'hF, 4'hF, 4'(cents / 100), 4'((cents / 10) % 10), 4'(cents % 10)};
            5: g = '{4'hC, 4'hF, 4'hF, 4'(cents / 100), 4'((cents / 10) % 10), 4'(cents % 10)};
            default: ;
        endcase
        d = '1;
        for (int k = 0; k < 6; k++) d[4*k +: 4] = g[k];
        bl = (m == 3) || (m == 5);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input int m, input logic [7:0] it, input int ins, input int rf);
        logic [DW-1:0] d;
        bit ov;
        bit bl;
        model(m, it, ins, rf, d, ov, bl);
        exp_q.push_back(d);
        exp_ovf_q.push_back(ov);
        exp_blink_q.push_back(bl);
        upd_if.mode      = 3'(m);
        upd_if.itemcode  = it;
        upd_if.inserted  = MW'(ins);
        upd_if.refund    = MW'(rf);
        upd_if.upd_valid = 1'b1;
    endtask

    task automatic scramble();
        upd_if.mode     = 3'($urandom);
        upd_if.itemcode = 8'($urandom);
        upd_if.inserted = MW'($urandom);
        upd_if.refund   = MW'($urandom);
    endtask

    // Returns the number of edges waited before the accepting edge (40 = timeout).
    task automatic wait_accept(output int waited);
        bit rdy;
        waited = 40;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            rdy = upd_if.upd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                waited = n;
                return;
            end
        end
    endtask

    // Called right after the accepting edge; follows edges N+1..N+11.
    task automatic expect_commit();
        logic [DW-1:0] ed;
        bit eo;
        bit eb;
        ed = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        eb = exp_blink_q.pop_front();
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            if (c < 11) begin
                check("busy_ready", 32'(upd_if.upd_ready), 0);
                check("busy_dv", 32'(disp_valid), 0);
                check("hold_digits", 32'(digits_o), 32'(disp_now()));
                check("hold_ovf", 32'(ovf), 32'(shown_ovf));
            end else begin
                check("commit_dv", 32'(disp_valid), 1);
                check("commit_digits", 32'(digits_o), 32'(ed));
                check("commit_ovf", 32'(ovf), 32'(eo));
                check("commit_ready", 32'(upd_if.upd_ready), 1);
                shown_content = ed;
                shown_ovf     = eo;
                shown_blinks  = eb;
                commit_cyc    = cyc;
                exp_pulses++;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_digits", 32'(digits_o), 32'(disp_now()));
            check("idle_dv", 32'(disp_valid), 0);
            check("idle_ready", 32'(upd_if.upd_ready), 1);
        end
    endtask

    task automatic request(input int m, input logic [7:0] it, input int ins, input int rf);
        int w;
        drive(m, it, ins, rf);
        wait_accept(w);
        check("accept_wait", 32'(w), 0);
        upd_if.upd_valid = 1'b0;
        scramble();
        expect_commit();
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] item_tab [6];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        item_tab = '{8'hA2, 8'hB3, 8'hD5, 8'hE8, 8'h77, 8'h00};
        upd_if.upd_valid = 1'b0;
        scramble();

        #2 rst_n = 1'b0;
        #1;
        check("rst_digits", 32'(digits_o), 32'({DW{1'b1}}));
        check("rst_dv", 32'(disp_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_ready", 32'(upd_if.upd_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Directed screens
        request(4, 8'h00, 5, 0);
        idle_cycles(2);
        request(2, 8'hA2, 0, 0);
        request(2, 8'h77, 0, 0);
        request(1, 8'h00, 0, 0);
        request(3, 8'h00, 0, 0);
        idle_cycles(12);
        request(4, 8'h00, 63, 0);
        request(5, 8'h00, 0, 0);
        idle_cycles(10);
        request(0, 8'h00, 0, 0);

        // Held valid across two requests: second accepted on the edge after disp_valid
        drive(5, 8'h00, 7, 40);
        wait_accept(w);
        check("held_first_accept", 32'(w), 0);
        drive(2, 8'hD5, 0, 0);
        expect_commit();
        wait_accept(w);
        check("held_second_accept", 32'(w), 0);
        upd_if.upd_valid = 1'b0;
        scramble();
        expect_commit();
        idle_cycles(3);

        // Reset in the middle of a conversion aborts it
        drive(4, 8'h00, 5, 0);
        wait_accept(w);
        check("abort_accept", 32'(w), 0);
        upd_if.upd_valid = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_ovf_q.pop_front());
        void'(exp_blink_q.pop_front());
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_digits", 32'(digits_o), 32'({DW{1'b1}}));
        check("abort_dv", 32'(disp_valid), 0);
        check("abort_ovf", 32'(ovf), 0);
        check("abort_ready", 32'(upd_if.upd_ready), 1);
        check("abort_state", 32'(dbg_state), 32'(S_READY));
        shown_content = '1;
        shown_ovf     = 1'b0;
        shown_blinks  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(15);

        // Randomized requests
        for (int i = 0; i < 24; i++) begin
            int m;
            logic [7:0] it;
            m  = int'($urandom_range(0, 7));
            it = ($urandom_range(0, 3) == 0) ? 8'($urandom) : item_tab[$urandom_range(0, 5)];
            request(m, it, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            idle_cycles(int'($urandom_range(0, 6)));
        end

        @(negedge clk);
        check("dv_pulse_count", 32'(dv_pulses), 32'(exp_pulses));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
